// File: rtl/calc_executor.sv
// calc_executor: captures two unsigned operands on a synchronised rising edge
// of E, then runs add, absolute subtract or a sequential shift-add multiply.
// RESULT, NEG and ERR are registered; DONE pulses once per completed operation.
module calc_executor #(
  parameter int         WIDTH  = 4,
  parameter logic [3:0] OP_ADD = 4'b1010,
  parameter logic [3:0] OP_SUB = 4'b1011,
  parameter logic [3:0] OP_MUL = 4'b1100
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET_N,
  input  logic [3:0]           OP,
  input  logic                 E,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   RESULT,
  output logic                 NEG,
  output logic                 ERR,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, FIN} state_t;

  state_t            state, state_d;
  logic              e_s1, e_s2, e_prev;
  logic              rise, capture;
  logic [3:0]        op_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [RW-1:0]     a_ext, b_ext;
  logic [RW-1:0]     acc, mcand;
  logic [WIDTH-1:0]  mplier;
  logic [CW-1:0]     cnt;

  assign rise    = e_s2 & ~e_prev;
  assign capture = rise && (state == IDLE);
  assign a_ext   = {{WIDTH{1'b0}}, a_q};
  assign b_ext   = {{WIDTH{1'b0}}, b_q};

  // Two-flop synchroniser for E plus a history flop for rising-edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser chain.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      e_s1   <= 1'b0;
      e_s2   <= 1'b0;
      e_prev <= 1'b0;
    end else begin
      e_s1   <= E;
      e_s2   <= e_s1;
      e_prev <= e_s2;
    end
  end

  // FSM state register.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_d;
  end

  // Next-state logic.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (capture) state_d = EXEC;
      EXEC: state_d = (op_q == OP_MUL) ? MUL : IDLE;
      MUL:  if (cnt == CW'(1)) state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, arithmetic datapath and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      RESULT <= '0;
      NEG    <= 1'b0;
      ERR    <= 1'b0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (capture) begin
            op_q <= OP;
            a_q  <= A;
            b_q  <= B;
            BUSY <= 1'b1;
            NEG  <= 1'b0;
            ERR  <= 1'b0;
          end
        end
        EXEC: begin
          if (op_q == OP_MUL) begin
            acc    <= '0;
            mcand  <= a_ext;
            mplier <= b_q;
            cnt    <= CW'(WIDTH);
          end else begin
            DONE <= 1'b1;
            BUSY <= 1'b0;
            if (op_q == OP_ADD) begin
              RESULT <= a_ext + b_ext;
            end else if (op_q == OP_SUB) begin
              if (a_q >= b_q) begin
                RESULT <= a_ext - b_ext;
                NEG    <= 1'b0;
              end else begin
                RESULT <= b_ext - a_ext;
                NEG    <= 1'b1;
              end
            end else begin
              RESULT <= '0;
              ERR    <= 1'b1;
            end
          end
        end
        MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
        end
        FIN: begin
          RESULT <= acc;
          DONE   <= 1'b1;
          BUSY   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_executor.sv
// Testbench for calc_executor: table vectors, hand-written corner sequences
// and randomised operations checked against an arithmetic reference model.
module tb_calc_executor;

  localparam int         WIDTH  = 4;
  localparam logic [3:0] OP_ADD = 4'b1010;
  localparam logic [3:0] OP_SUB = 4'b1011;
  localparam logic [3:0] OP_MUL = 4'b1100;

  logic               clk;
  logic               rst_n;
  logic [3:0]         op;
  logic               e;
  logic [WIDTH-1:0]   a, b;
  logic [2*WIDTH-1:0] result;
  logic               neg, err, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  calc_executor #(.WIDTH(WIDTH), .OP_ADD(OP_ADD), .OP_SUB(OP_SUB), .OP_MUL(OP_MUL)) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .OP(op), .E(e), .A(a), .B(b),
    .RESULT(result), .NEG(neg), .ERR(err), .BUSY(busy), .DONE(done)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] op;
    int         a, b;
    int         res;
    logic       neg, err;
  } vec_t;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference: {err, neg, result} from plain integer arithmetic.
  function automatic void model(input logic [3:0] m_op, input int ma, input int mb,
                                output int res, output logic mneg, output logic merr);
    res = 0; mneg = 1'b0; merr = 1'b0;
    if (m_op == OP_ADD)      res = ma + mb;
    else if (m_op == OP_SUB) begin
      res  = (ma >= mb) ? ma - mb : mb - ma;
      mneg = (ma < mb);
    end
    else if (m_op == OP_MUL) res = ma * mb;
    else                     merr = 1'b1;
  endfunction

  // Edges from the first E sample to the DONE edge, counting that sample as 1.
  function automatic int exp_latency(input logic [3:0] m_op);
    return (m_op == OP_MUL) ? WIDTH + 5 : 4;
  endfunction

  // Raise E with the given operands, wait for DONE (bounded), check the
  // pulse is single, then release E long enough for a clean re-press.
  task automatic run_op(input logic [3:0] t_op, input int ta, input int tb,
                        output int res, output logic rneg, output logic rerr, output int lat);
    @(negedge clk);
    op = t_op; a = WIDTH'(ta); b = WIDTH'(tb); e = 1'b1;
    lat = -1; res = -1; rneg = 1'bx; rerr = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i; res = int'(result); rneg = neg; rerr = err;
        break;
      end
      if (i == 3) begin
        // Operands were captured at the previous edge; scramble them.
        a = ~a; b = ~b; op = op ^ 4'b0110;
      end
    end
    if (lat > 0) begin
      @(posedge clk); #1;
      check("done_single_pulse", int'(done), 0);
      check("busy_after_done", int'(busy), 0);
    end
    @(negedge clk);
    e = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  vec_t vecs[10];
  int   got_res, got_lat, exp_res, done_cnt;
  logic got_neg, got_err, exp_neg, exp_err;

  initial begin
    vecs[0] = '{OP_ADD,  9,  5,  14, 1'b0, 1'b0};
    vecs[1] = '{OP_SUB,  5,  9,   4, 1'b1, 1'b0};
    vecs[2] = '{OP_SUB,  9,  9,   0, 1'b0, 1'b0};
    vecs[3] = '{OP_MUL, 15, 15, 225, 1'b0, 1'b0};
    vecs[4] = '{OP_MUL,  0, 13,   0, 1'b0, 1'b0};
    vecs[5] = '{4'b0000, 3,  3,   0, 1'b0, 1'b1};
    vecs[6] = '{4'b1101, 7,  2,   0, 1'b0, 1'b1};
    vecs[7] = '{OP_ADD,  1,  1,   2, 1'b0, 1'b0};
    vecs[8] = '{OP_ADD, 15, 15,  30, 1'b0, 1'b0};
    vecs[9] = '{OP_MUL, 11,  6,  66, 1'b0, 1'b0};

    rst_n = 1'b0; e = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_result", int'(result), 0);
    check("reset_flags", int'({neg, err, busy, done}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven vectors.
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, got_res, got_neg, got_err, got_lat);
      check($sformatf("vec%0d_latency", i), got_lat, exp_latency(vecs[i].op));
      check($sformatf("vec%0d_result", i), got_res, vecs[i].res);
      check($sformatf("vec%0d_neg", i), int'(got_neg), int'(vecs[i].neg));
      check($sformatf("vec%0d_err", i), int'(got_err), int'(vecs[i].err));
    end

    // E held high ~50 cycles, with a drop and re-rise while the MUL is busy.
    done_cnt = 0;
    @(negedge clk);
    op = OP_MUL; a = 4'd15; b = 4'd15; e = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done) begin
        done_cnt++;
        got_res = int'(result);
      end
      @(negedge clk);
      if (i == 3) e = 1'b0;
      if (i == 5) e = 1'b1;
    end
    check("held_e_done_count", done_cnt, 1);
    check("held_e_result", got_res, 225);
    e = 1'b0;
    repeat (3) @(negedge clk);

    // Reset asserted at C+3 of a MUL aborts it without DONE.
    @(negedge clk);
    op = OP_MUL; a = 4'd15; b = 4'd15; e = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("pre_reset_busy", int'(busy), 1);
    #3;
    rst_n = 1'b0; e = 1'b0;
    #1;
    check("async_reset_result", int'(result), 0);
    check("async_reset_flags", int'({neg, err, busy, done}), 0);
    done_cnt = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done || busy) done_cnt++;
    end
    check("post_reset_idle", done_cnt, 0);
    run_op(OP_ADD, 3, 4, got_res, got_neg, got_err, got_lat);
    check("post_reset_add", got_res, 7);
    check("post_reset_add_latency", got_lat, 4);

    // Randomised operations against the reference model.
    for (int i = 0; i < 30; i++) begin
      logic [3:0] r_op;
      int ra, rb;
      case ($urandom_range(0, 3))
        0:       r_op = OP_ADD;
        1:       r_op = OP_SUB;
        2:       r_op = OP_MUL;
        default: r_op = 4'($urandom);
      endcase
      ra = int'($urandom_range(0, 15));
      rb = int'($urandom_range(0, 15));
      model(r_op, ra, rb, exp_res, exp_neg, exp_err);
      run_op(r_op, ra, rb, got_res, got_neg, got_err, got_lat);
      check($sformatf("rand%0d_latency", i), got_lat, exp_latency(r_op));
      check($sformatf("rand%0d_result op=%b a=%0d b=%0d", i, r_op, ra, rb), got_res, exp_res);
      check($sformatf("rand%0d_flags", i), int'({got_neg, got_err}), int'({exp_neg, exp_err}));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
